// File: rtl/mips_instruction_fetch_pkg.sv
// Shared MIPS fetch-stage types and constants.
package mips_pkg;

  localparam int unsigned MIPS_XLEN = 32;

  localparam logic [MIPS_XLEN-1:0] MIPS_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [MIPS_XLEN-1:0] MIPS_HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_HOLD   = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } fetch_state_t;

  // Little-endian memory word to MIPS big-endian word.
  function automatic logic [MIPS_XLEN-1:0] mips_bswap32(input logic [MIPS_XLEN-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/mips_instruction_fetch_if.sv
// Fetch-stage bus: PC input, instruction memory port, decode handshake, status.
interface mips_instruction_fetch_if;
  import mips_pkg::*;

  logic [MIPS_XLEN-1:0] pc;
  logic [MIPS_XLEN-1:0] mem_address;
  logic                 mem_read;
  logic                 mem_waitrequest;
  logic [MIPS_XLEN-1:0] mem_readdata;
  logic [MIPS_XLEN-1:0] instr;
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 cnt_en;
  logic                 active;
  logic                 fault;

  modport master (
    input  pc, mem_waitrequest, mem_readdata, instr_ready,
    output mem_address, mem_read, instr, instr_valid, cnt_en, active, fault
  );

  modport slave (
    output pc, mem_waitrequest, mem_readdata, instr_ready,
    input  mem_address, mem_read, instr, instr_valid, cnt_en, active, fault
  );

endinterface

// File: rtl/mips_instruction_fetch_byte_swap.sv
// Combinational 32-bit byte reversal, shared with the data-memory path.
module mips_byte_swap
  import mips_pkg::*;
(
  input  logic [MIPS_XLEN-1:0] word_i,
  output logic [MIPS_XLEN-1:0] word_o
);

  assign word_o = mips_bswap32(word_i);

endmodule

// File: rtl/mips_instruction_fetch.sv
// Instruction fetch: reads the word at pc, holds it for decode, strobes the PC
// once per consumed instruction, and stops on a halt address or misaligned pc.
module mips_instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [MIPS_XLEN-1:0] HALT_ADDR  = MIPS_HALT_ADDR,
  parameter bit                   SWAP_BYTES = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  mips_instruction_fetch_if.master bus
);

  fetch_state_t         state_q, state_d;
  logic [MIPS_XLEN-1:0] instr_q, instr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 fault_q, fault_d;
  logic [MIPS_XLEN-1:0] swapped_w;
  logic [MIPS_XLEN-1:0] rdata_w;
  logic                 read_c;

  mips_byte_swap u_byte_swap (
    .word_i (bus.mem_readdata),
    .word_o (swapped_w)
  );

  assign rdata_w = SWAP_BYTES ? swapped_w : bus.mem_readdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  // Next-state and combinational outputs
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    read_c        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Halt takes priority over the alignment check.
        if (bus.pc == HALT_ADDR) begin
          state_d = ST_HALTED;
        end else if (bus.pc[1:0] != 2'b00) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          read_c = 1'b1;
          if (!bus.mem_waitrequest) begin
            instr_d       = rdata_w;
            instr_valid_d = 1'b1;
            state_d       = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = ST_FETCH;
        end
      end
      ST_HALTED, ST_FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.mem_read    = read_c;
  assign bus.mem_address = read_c ? bus.pc : '0;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.cnt_en      = (state_q == ST_HOLD) && bus.instr_ready;
  assign bus.active      = (state_q != ST_HALTED) && (state_q != ST_FAULT);
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_mips_instruction_fetch.sv
// Directed self-checking bench for mips_instruction_fetch.
module tb_mips_instruction_fetch;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pulses = 0;
  int   base;

  mips_instruction_fetch_if fif ();

  mips_instruction_fetch #(
    .HALT_ADDR  (32'h0000_0000),
    .SWAP_BYTES (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (fif.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fif.cnt_en) pulses <= pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                 = 1'b1;
    fif.pc              = MIPS_RESET_VECTOR;
    fif.mem_waitrequest = 1'b0;
    fif.mem_readdata    = 32'h7856_3412;
    fif.instr_ready     = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_mem_read", 32'(fif.mem_read), 32'd0);
    chk("rst_mem_address", fif.mem_address, 32'h0);
    chk("rst_instr", fif.instr, 32'h0);
    chk("rst_instr_valid", 32'(fif.instr_valid), 32'd0);
    chk("rst_cnt_en", 32'(fif.cnt_en), 32'd0);
    chk("rst_active", 32'(fif.active), 32'd1);
    chk("rst_fault", 32'(fif.fault), 32'd0);

    // Zero-wait fetch at the reset vector
    rst = 1'b0;
    fif.instr_ready = 1'b1;
    base = pulses;
    step();  // FETCH
    chk("f0_mem_read", 32'(fif.mem_read), 32'd1);
    chk("f0_mem_address", fif.mem_address, 32'hBFC0_0000);
    chk("f0_valid", 32'(fif.instr_valid), 32'd0);
    chk("f0_cnt_en", 32'(fif.cnt_en), 32'd0);
    step();  // HOLD
    chk("f0_instr", fif.instr, 32'h1234_5678);
    chk("f0_hold_valid", 32'(fif.instr_valid), 32'd1);
    chk("f0_hold_cnt_en", 32'(fif.cnt_en), 32'd1);
    chk("f0_hold_mem_read", 32'(fif.mem_read), 32'd0);
    step();  // FETCH of next pc
    chk("f0_pulses", 32'(pulses - base), 32'd1);

    // Three wait-state cycles
    fif.pc = 32'hBFC0_0004;
    fif.mem_waitrequest = 1'b1;
    fif.mem_readdata = 32'hDDCC_BBAA;
    base = pulses;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("w_mem_read", 32'(fif.mem_read), 32'd1);
      chk("w_mem_address", fif.mem_address, 32'hBFC0_0004);
      chk("w_cnt_en", 32'(fif.cnt_en), 32'd0);
      step();
    end
    fif.mem_waitrequest = 1'b0;
    fif.mem_readdata = 32'h4433_2211;
    #1;
    chk("w4_mem_read", 32'(fif.mem_read), 32'd1);
    chk("w4_mem_address", fif.mem_address, 32'hBFC0_0004);
    chk("w4_valid", 32'(fif.instr_valid), 32'd0);
    step();  // HOLD
    chk("w_instr", fif.instr, 32'h1122_3344);
    chk("w_valid", 32'(fif.instr_valid), 32'd1);
    step();  // FETCH
    chk("w_pulses", 32'(pulses - base), 32'd1);

    // Decode stalls five cycles in HOLD
    fif.pc = 32'hBFC0_0008;
    fif.mem_readdata = 32'hEFBE_ADDE;
    fif.instr_ready = 1'b0;
    base = pulses;
    step();  // HOLD
    fif.mem_readdata = 32'h0BAD_F00D;
    for (int i = 0; i < 5; i++) begin
      chk("s_instr", fif.instr, 32'hDEAD_BEEF);
      chk("s_valid", 32'(fif.instr_valid), 32'd1);
      chk("s_cnt_en", 32'(fif.cnt_en), 32'd0);
      chk("s_mem_read", 32'(fif.mem_read), 32'd0);
      step();
    end
    chk("s_no_pulse", 32'(pulses - base), 32'd0);
    fif.instr_ready = 1'b1;
    #1;
    chk("s_release_cnt_en", 32'(fif.cnt_en), 32'd1);
    fif.pc = 32'hBFC0_000C;
    step();  // FETCH
    chk("s_pulses", 32'(pulses - base), 32'd1);
    chk("s_refetch_read", 32'(fif.mem_read), 32'd1);
    chk("s_refetch_addr", fif.mem_address, 32'hBFC0_000C);

    // Jump to 0 halts
    fif.pc = 32'h0;
    #1;
    chk("h_mem_read", 32'(fif.mem_read), 32'd0);
    step();  // HALTED
    base = pulses;
    for (int i = 0; i < 10; i++) begin
      chk("h_active", 32'(fif.active), 32'd0);
      chk("h_mem_read_halted", 32'(fif.mem_read), 32'd0);
      chk("h_valid", 32'(fif.instr_valid), 32'd0);
      step();
    end
    chk("h_fault", 32'(fif.fault), 32'd0);
    chk("h_no_pulse", 32'(pulses - base), 32'd0);
    rst = 1'b1;
    step();
    chk("h_rst_active", 32'(fif.active), 32'd1);

    // Misaligned fetch faults
    fif.pc = 32'hBFC0_0002;
    rst = 1'b0;
    step();  // FETCH
    chk("m_mem_read", 32'(fif.mem_read), 32'd0);
    step();  // FAULT
    chk("m_fault", 32'(fif.fault), 32'd1);
    chk("m_active", 32'(fif.active), 32'd0);
    step();
    chk("m_fault_sticky", 32'(fif.fault), 32'd1);
    chk("m_mem_read_after", 32'(fif.mem_read), 32'd0);

    // Reset in the middle of a stalled read
    rst = 1'b1;
    step();
    fif.pc = MIPS_RESET_VECTOR;
    fif.mem_waitrequest = 1'b1;
    fif.mem_readdata = 32'h7856_3412;
    rst = 1'b0;
    step();  // FETCH
    chk("r_pre_mem_read", 32'(fif.mem_read), 32'd1);
    step();
    chk("r_pre_mem_read2", 32'(fif.mem_read), 32'd1);
    rst = 1'b1;
    step();  // IDLE
    chk("r_mem_read", 32'(fif.mem_read), 32'd0);
    chk("r_mem_address", fif.mem_address, 32'h0);
    chk("r_active", 32'(fif.active), 32'd1);
    chk("r_fault", 32'(fif.fault), 32'd0);
    chk("r_instr", fif.instr, 32'h0);
    rst = 1'b0;
    fif.mem_waitrequest = 1'b0;
    step();  // FETCH
    chk("r_restart_read", 32'(fif.mem_read), 32'd1);
    chk("r_restart_addr", fif.mem_address, 32'hBFC0_0000);
    step();  // HOLD
    chk("r_restart_instr", fif.instr, 32'h1234_5678);
    chk("r_restart_valid", 32'(fif.instr_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
